alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one alu_top instance between NUM_REQ independent requesters.
- Round-robin arbitration, one operation in flight at a time.
- Sequences the ALU start/ready handshake, latches operands, returns result and flags to the granted requester only.
- Sits between the client blocks and alu_top; it is the only driver of alu_top's operand, operation and start inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles waiting for alu_ready before abort (used only with ALU_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until matching req_ready pulse.
- req_operand_a  in  8*NUM_REQ  flattened operand A, slice i = [8i+7:8i].
- req_operand_b  in  8*NUM_REQ  flattened operand B.
- req_operation  in  2*NUM_REQ  flattened opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- req_ready  out  NUM_REQ  one-hot grant pulse; request accepted this cycle.
- resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- resp_result  out  16  result of the completed op (DIV: [7:0] quotient, [15:8] remainder).
- resp_overflow  out  1  alu overflow flag, qualified by resp_valid.
- resp_zero  out  1  alu zero flag, qualified by resp_valid.
- resp_timeout  out  1  op aborted by watchdog, qualified by resp_valid.
- busy  out  1  high in every state except IDLE.
- alu_operand_a  out  8  to alu_top.
- alu_operand_b  out  8  to alu_top.
- alu_operation  out  2  to alu_top.
- alu_start  out  1  one-cycle start pulse to alu_top.
- alu_result  in  16  from alu_top.
- alu_ready  in  1  from alu_top.
- alu_overflow  in  1  from alu_top.
- alu_zero  in  1  from alu_top.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0, including the alu_* operand/operation registers.
  - RR pointer is set to NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE -> ISSUE -> SETTLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, select the first set bit searching from pointer+1 (modulo NUM_REQ).
  - Pulse req_ready[sel] for one cycle; latch its a/b/op into the alu_* registers; store sel; pointer <= sel.
  - Next state is ISSUE.
  - If no request, stay in IDLE.
- ISSUE: alu_start=1 for exactly one cycle; go to SETTLE.
- SETTLE: alu_ready ignored for one cycle, which masks a stale ready from the previous op; go to WAIT.
- WAIT:
  - When alu_ready=1, capture alu_result, alu_overflow and alu_zero into the resp registers; go to RESP.
  - alu_operand_a, alu_operand_b and alu_operation stay stable from ISSUE until RESP exits.
- RESP:
  - resp_valid[sel]=1 for one cycle; resp_* hold their values until the next RESP.
  - Next state is IDLE. The earliest next grant is the cycle after RESP.
- Latency: grant at cycle G, alu_start at G+1, resp_valid = (cycle alu_ready is sampled in WAIT) + 1.
- Requests arriving while busy are ignored until IDLE; req_valid must stay high, and the arbiter never drops a held request.
- req_valid deasserted before grant: no grant, no side effects.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- A requester with a single outstanding op may reassert req_valid in the cycle its resp_valid is high; it is eligible in the next IDLE.
- Arithmetic is entirely in alu_top; the arbiter passes data through unmodified. DIV-by-zero is reported via resp_overflow as alu_top sets it.
- reset asserted mid-operation: immediate abort, no resp_valid for the in-flight op, alu_start=0. The ALU is reset by the same net.

Optional Feature:
- ALU_ARB_TIMEOUT_EN defined:
  - A cycle counter is cleared in ISSUE and increments in SETTLE/WAIT.
  - On reaching TIMEOUT without alu_ready: go to RESP with resp_timeout=1, resp_result=16'h0000, resp_overflow=1, resp_zero=0.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - resp_timeout is tied to 0.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - FSM state encoding constants.
  - result width 16, operand width 8.
- Sub-module rr_arbiter (NUM_REQ): combinational pick from the req vector and pointer, plus the registered pointer with update-enable. The top holds the FSM, latches and watchdog.

Test Plan:
- Req0 only, a=5 b=3 op=00 -> req_ready[0] pulse, alu_start 1 cycle later, resp_valid[0]=1, resp_result=16'd8, zero=0.
- Req0 and req2 simultaneous: req2 7*6 op=10, req0 20/4 op=11 -> req0 granted first, resp quotient 5; then req2, resp_result=16'd42; never two grants in flight.
- All 4 continuously valid for 8 ops -> grant order 0,1,2,3,0,1,2,3; each resp_valid goes only to its granter.
- Req1 17/5 op=11 -> resp_result=16'h0203. Req1 25/0 -> resp_overflow=1.
- reset low during WAIT -> all outputs 0 asynchronously, no resp_valid; after release, requester 0 wins first.
- ALU_ARB_TIMEOUT_EN with TIMEOUT=8 and alu_ready stuck 0 -> resp_valid with resp_timeout=1, overflow=1, result=0 at start+10 cycles; arbiter then returns to IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter slice: opcodes, widths, FSM states.
// No ports; imported by alu_arbiter and rr_arbiter.
package alu_pkg;

    localparam int OPND_W = 8;
    localparam int RES_W  = 16;
    localparam int OP_W   = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set req bit after ptr (mod NUM_REQ).
// Ports: clk, reset (async, low), req, update -> grant, grant_idx, any.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       update,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int cand;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[IDX_W'(cand)]) begin
                any       = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        grant = any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    // Reset to the last slot so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (update) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu_top between NUM_REQ requesters, round-robin, one op in flight.
// Ports: req_* (in), req_ready/resp_* (out), alu_* to/from alu_top.
// Optional watchdog on alu_ready: define ALU_ARB_TIMEOUT_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [OPND_W*NUM_REQ-1:0]   req_operand_a,
    input  logic [OPND_W*NUM_REQ-1:0]   req_operand_b,
    input  logic [OP_W*NUM_REQ-1:0]     req_operation,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [RES_W-1:0]            resp_result,
    output logic                        resp_overflow,
    output logic                        resp_zero,
    output logic                        resp_timeout,
    output logic                        busy,
    output logic [OPND_W-1:0]           alu_operand_a,
    output logic [OPND_W-1:0]           alu_operand_b,
    output logic [OP_W-1:0]             alu_operation,
    output logic                        alu_start,
    input  logic [RES_W-1:0]            alu_result,
    input  logic                        alu_ready,
    input  logic                        alu_overflow,
    input  logic                        alu_zero
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    state_t             state_nx;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   sel;
    logic               any;
    logic               accept;
    logic               expired;

    // Grant is combinational in IDLE; held low while reset is asserted.
    assign accept = (state == ST_IDLE) && any && reset;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .update    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;

    assign expired = (wd_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wd_cnt <= '0;
        end else if ((state == ST_SETTLE || state == ST_WAIT)
                     && !expired) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_timeout <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (alu_ready) begin
                resp_timeout <= 1'b0;
            end else if (expired) begin
                resp_timeout <= 1'b1;
            end
        end
    end
`else
    // Watchdog compiled out: WAIT never expires.
    assign expired      = (TIMEOUT < 0);
    assign resp_timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (any) state_nx = ST_ISSUE;
            ST_ISSUE:  state_nx = ST_SETTLE;
            ST_SETTLE: state_nx = ST_WAIT;
            ST_WAIT:   if (alu_ready || expired) state_nx = ST_RESP;
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            sel           <= '0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_operation <= '0;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
            resp_zero     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sel           <= grant_idx;
                alu_operand_a <= req_operand_a[{grant_idx, 3'b000} +: OPND_W];
                alu_operand_b <= req_operand_b[{grant_idx, 3'b000} +: OPND_W];
                alu_operation <= req_operation[{grant_idx, 1'b0} +: OP_W];
            end
            if (state == ST_WAIT) begin
                if (alu_ready) begin
                    resp_result   <= alu_result;
                    resp_overflow <= alu_overflow;
                    resp_zero     <= alu_zero;
                end else if (expired) begin
                    resp_result   <= '0;
                    resp_overflow <= 1'b1;
                    resp_zero     <= 1'b0;
                end
            end
        end
    end

    assign req_ready  = accept ? grant : '0;
    assign alu_start  = (state == ST_ISSUE);
    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_RESP) ? (NUM_REQ'(1) << sel) : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural alu_top stand-in.
// Scoreboard filled at grant, drained on resp_valid.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [8*N-1:0]    req_operand_a = '0;
    logic [8*N-1:0]    req_operand_b = '0;
    logic [2*N-1:0]    req_operation = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [15:0]       resp_result;
    logic              resp_overflow;
    logic              resp_zero;
    logic              resp_timeout;
    logic              busy;
    logic [7:0]        alu_operand_a;
    logic [7:0]        alu_operand_b;
    logic [1:0]        alu_operation;
    logic              alu_start;
    logic [15:0]       alu_result;
    logic              alu_ready;
    logic              alu_overflow;
    logic              alu_zero;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_operand_a (req_operand_a),
        .req_operand_b (req_operand_b),
        .req_operation (req_operation),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_result   (resp_result),
        .resp_overflow (resp_overflow),
        .resp_zero     (resp_zero),
        .resp_timeout  (resp_timeout),
        .busy          (busy),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_operation (alu_operation),
        .alu_start     (alu_start),
        .alu_result    (alu_result),
        .alu_ready     (alu_ready),
        .alu_overflow  (alu_overflow),
        .alu_zero      (alu_zero)
    );

    // Returns {overflow, zero, result} as the stand-in alu_top defines them.
    function automatic logic [17:0] alu_ref(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [1:0] op);
        logic [15:0] r;
        logic        ov;
        logic        z;
        r  = '0;
        ov = 1'b0;
        case (op)
            OP_ADD: begin r = 16'(a) + 16'(b); ov = r[8]; end
            OP_SUB: begin r = {8'h00, a - b}; ov = (a < b); end
            OP_MUL: begin r = 16'(a) * 16'(b); ov = (r[15:8] != 0); end
            default: begin
                if (b == 0) begin r = '0; ov = 1'b1; end
                else r = {a % b, a / b};
            end
        endcase
        z = (r == 0) && !(op == OP_DIV && b == 0);
        return {ov, z, r};
    endfunction

    // alu_top stand-in: start seen one cycle late, so the previous
    // ready is still high during SETTLE.
    logic       alu_stuck = 1'b0;
    logic       start_d;
    logic [2:0] lat_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_d      <= 1'b0;
            lat_cnt      <= '0;
            alu_ready    <= 1'b0;
            alu_result   <= '0;
            alu_overflow <= 1'b0;
            alu_zero     <= 1'b0;
        end else begin
            start_d <= alu_start;
            if (start_d) begin
                alu_ready <= 1'b0;
                lat_cnt   <= alu_stuck ? 3'd0 : 3'(LAT);
            end else if (lat_cnt != 0) begin
                lat_cnt <= lat_cnt - 1'b1;
                if (lat_cnt == 1) begin
                    {alu_overflow, alu_zero, alu_result} <=
                        alu_ref(alu_operand_a, alu_operand_b, alu_operation);
                    alu_ready <= 1'b1;
                end
            end
        end
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        logic [15:0] res;
        logic        ovf;
        logic        zero;
        logic        tmo;
    } op_t;

    typedef struct {
        int  idx;
        op_t o;
    } exp_t;

    op_t  pend[N][$];
    exp_t sb[$];
    int   grant_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   grant_cyc = 0;
    int   start_cyc = 0;
    bit   inflight = 1'b0;
    op_t  cur;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_op(input int r, input logic [7:0] a,
                          input logic [7:0] b, input logic [1:0] op,
                          input logic [15:0] res, input logic ovf,
                          input logic zero, input logic tmo);
        op_t o;
        o = '{a: a, b: b, op: op, res: res, ovf: ovf, zero: zero, tmo: tmo};
        pend[r].push_back(o);
    endtask

    task automatic add_rand(input int r, input logic [1:0] op);
        logic [7:0]  a;
        logic [7:0]  b;
        logic [17:0] x;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(1, 255));
        x = alu_ref(a, b, op);
        add_op(r, a, b, op, x[15:0], x[17], x[16], 1'b0);
    endtask

    // Each requester holds req_valid with its oldest op until granted.
    task automatic requesters();
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pend[i].size() != 0) begin
                    req_valid[i]             = 1'b1;
                    req_operand_a[i*8 +: 8]  = pend[i][0].a;
                    req_operand_b[i*8 +: 8]  = pend[i][0].b;
                    req_operation[i*2 +: 2]  = pend[i][0].op;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic monitor();
        int   idx;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (req_ready != 0) begin
                chk("one_hot_grant", $countones(req_ready), 1);
                chk("no_overlap", 32'(inflight), 0);
                idx = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                grant_log.push_back(idx);
                chk("grant_has_req", 32'(pend[idx].size() != 0), 1);
                if (pend[idx].size() != 0) begin
                    cur = pend[idx].pop_front();
                    sb.push_back('{idx: idx, o: cur});
                    inflight  = 1'b1;
                    grant_cyc = cyc;
                end
            end
            if (alu_start) begin
                chk("start_latency", cyc - grant_cyc, 1);
                chk("start_opa", alu_operand_a, cur.a);
                chk("start_opb", alu_operand_b, cur.b);
                chk("start_op", alu_operation, cur.op);
                start_cyc = cyc;
            end
            if (resp_valid != 0) begin
                chk("resp_has_exp", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("resp_valid", resp_valid, N'(1) << e.idx);
                    chk("resp_result", resp_result, e.o.res);
                    chk("resp_overflow", resp_overflow, e.o.ovf);
                    chk("resp_zero", resp_zero, e.o.zero);
                    chk("resp_timeout", resp_timeout, e.o.tmo);
                    chk("resp_latency", cyc - start_cyc, e.o.tmo ? 10 : 6);
                    chk("hold_opa", alu_operand_a, e.o.a);
                end
                inflight = 1'b0;
            end
        end
    endtask

    function automatic bit any_pending();
        bit p;
        p = (sb.size() != 0) || inflight;
        for (int i = 0; i < N; i++) if (pend[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (any_pending() && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 32'(n < 300), 1);
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic chk_order(input string tag, input int exp[$]);
        chk({tag, "_ngrants"}, grant_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
            chk({tag, "_order"}, grant_log[i], exp[i]);
        grant_log.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_result"}, resp_result, 0);
        chk({tag, "_flags"}, {resp_overflow, resp_zero, resp_timeout}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_alu_start"}, alu_start, 0);
        chk({tag, "_alu_ops"},
            {alu_operand_a, alu_operand_b, alu_operation}, 0);
    endtask

    initial begin
        int n;
        fork
            monitor();
            requesters();
        join_none

        // Reset with a request already pending: no grant leaks out.
        add_op(0, 8'd5, 8'd3, OP_ADD, 16'd8, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_req_valid", req_valid[0], 1);
        chk_zero("rst");
        @(posedge clk);
        #1 reset = 1'b1;
        drain("add");
        chk_order("add", '{0});

        add_op(1, 8'd17, 8'd5, OP_DIV, 16'h0203, 1'b0, 1'b0, 1'b0);
        add_op(1, 8'd25, 8'd0, OP_DIV, 16'h0000, 1'b1, 1'b0, 1'b0);
        drain("div");
        chk_order("div", '{1, 1});

        add_op(3, 8'd9, 8'd9, OP_SUB, 16'h0000, 1'b0, 1'b1, 1'b0);
        drain("zero");
        chk_order("zero", '{3});

        add_op(2, 8'd7, 8'd6, OP_MUL, 16'd42, 1'b0, 1'b0, 1'b0);
        add_op(0, 8'd20, 8'd4, OP_DIV, 16'd5, 1'b0, 1'b0, 1'b0);
        drain("pair");
        chk_order("pair", '{0, 2});

        add_op(3, 8'd3, 8'd5, OP_SUB, 16'h00FE, 1'b1, 1'b0, 1'b0);
        drain("borrow");
        chk_order("borrow", '{3});

        for (int rnd = 0; rnd < 2; rnd++)
            for (int r = 0; r < N; r++)
                add_rand(r, 2'((r + rnd) % 4));
        drain("fair");
        chk_order("fair", '{0, 1, 2, 3, 0, 1, 2, 3});

        // Abort an op in WAIT; pointer must restart at requester 0.
        add_op(1, 8'd200, 8'd100, OP_ADD, 16'h012C, 1'b1, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!alu_start && n < 50);
        chk("abort_start_seen", alu_start, 1);
        repeat (3) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk_zero("abort");
        pend[1].delete();
        sb.delete();
        inflight = 1'b0;
        grant_log.delete();
        add_op(2, 8'd100, 8'd2, OP_MUL, 16'd200, 1'b0, 1'b0, 1'b0);
        add_op(0, 8'd250, 8'd10, OP_ADD, 16'd260, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_hold_valid", req_valid, 4'b0101);
        chk("abort_hold_ready", req_ready, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        drain("post_rst");
        chk_order("post_rst", '{0, 2});

`ifdef ALU_ARB_TIMEOUT_EN
        alu_stuck = 1'b1;
        add_op(2, 8'd1, 8'd1, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain("tmo");
        chk_order("tmo", '{2});
        alu_stuck = 1'b0;
        add_op(1, 8'd4, 8'd4, OP_MUL, 16'd16, 1'b0, 1'b0, 1'b0);
        drain("after_tmo");
        chk_order("after_tmo", '{1});
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
